uart_tx_arbiter: RTL

Shares the single UART transmit byte interface between two frame sources: waveform sample telemetry (32-bit) and command status/ack responses (16-bit).
- Captures one request word per frame and serialises it as SOM + payload bytes (MSB first) + EOM.
- Arbitrates round-robin at frame granularity; a frame is never interrupted.
- Enforces a programmable idle gap between frames.
- Sits between the signal/command logic and the UART IP's write port.

---
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin framer that shares one UART byte port between 32-bit sample and 16-bit status words.
// Define UART_TX_CHECKSUM_EN to append an XOR checksum byte after the payload.
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [7:0]  SAMPLE_SOM = 8'h73,
  parameter logic [7:0]  STATUS_SOM = 8'h72,
  parameter logic [7:0]  EOM_CHAR   = 8'h65
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        sample_ready,
  input  logic        status_valid,
  input  logic [15:0] status_data,
  output logic        status_ready,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  output logic        to_uart_error,
  input  logic        to_uart_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic GRANT_SAMPLE = 1'b0;
  localparam logic GRANT_STATUS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOM,
    ST_PAYLOAD,
`ifdef UART_TX_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_EOM,
    ST_GAP
  } state_t;

  state_t             r_state;
  logic [31:0]        r_shift;
  logic [1:0]         r_byte_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_last_grant;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_sample_ready;
  logic               r_status_ready;
  logic               r_busy;
  logic [15:0]        r_frame_count;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_xfer;
  logic               w_grant_sample;
  logic               w_grant_status;
  logic [7:0]         w_next_byte;

  assign w_xfer         = r_valid & to_uart_ready;
  // On a tie the source that did not win last time takes the frame.
  assign w_grant_sample = sample_valid & (~status_valid | (r_last_grant == GRANT_STATUS));
  assign w_grant_status = status_valid & ~w_grant_sample;
  assign w_next_byte    = r_shift[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_shift        <= 32'd0;
      r_byte_cnt     <= 2'd0;
      r_gap_cnt      <= '0;
      r_last_grant   <= GRANT_STATUS;
      r_data         <= 8'd0;
      r_valid        <= 1'b0;
      r_sample_ready <= 1'b0;
      r_status_ready <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_count  <= 16'd0;
`ifdef UART_TX_CHECKSUM_EN
      r_csum         <= 8'd0;
`endif
    end else begin
      r_sample_ready <= 1'b0;
      r_status_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_sample) begin
            r_shift        <= sample_data;
            r_byte_cnt     <= 2'd3;
            r_sample_ready <= 1'b1;
            r_last_grant   <= GRANT_SAMPLE;
            r_data         <= SAMPLE_SOM;
          end else if (w_grant_status) begin
            // Status payload is left-aligned so both frame types shift out of the top byte.
            r_shift        <= {status_data, 16'h0000};
            r_byte_cnt     <= 2'd1;
            r_status_ready <= 1'b1;
            r_last_grant   <= GRANT_STATUS;
            r_data         <= STATUS_SOM;
          end
          if (w_grant_sample || w_grant_status) begin
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_SOM;
          end
        end
        ST_SOM: begin
          if (w_xfer) begin
            r_data  <= w_next_byte;
            r_shift <= {r_shift[23:0], 8'h00};
`ifdef UART_TX_CHECKSUM_EN
            r_csum  <= w_next_byte;
`endif
            r_state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            if (r_byte_cnt != 2'd0) begin
              r_data     <= w_next_byte;
              r_shift    <= {r_shift[23:0], 8'h00};
              r_byte_cnt <= r_byte_cnt - 2'd1;
`ifdef UART_TX_CHECKSUM_EN
              r_csum     <= r_csum ^ w_next_byte;
`endif
            end else begin
`ifdef UART_TX_CHECKSUM_EN
              r_data  <= r_csum;
              r_state <= ST_CSUM;
`else
              r_data  <= EOM_CHAR;
              r_state <= ST_EOM;
`endif
            end
          end
        end
`ifdef UART_TX_CHECKSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            r_data  <= EOM_CHAR;
            r_state <= ST_EOM;
          end
        end
`endif
        ST_EOM: begin
          if (w_xfer) begin
            r_valid       <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // The IDLE cycle that follows supplies the last of the GAP_CYCLES+1 quiet clocks.
          if (r_gap_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign to_uart_data  = r_data;
  assign to_uart_valid = r_valid;
  assign to_uart_error = 1'b0;
  assign sample_ready  = r_sample_ready;
  assign status_ready  = r_status_ready;
  assign busy          = r_busy;
  assign frame_count   = r_frame_count;

endmodule
